// File: rtl/shop_pkg.sv
// Shared types and constants for the four-item vending machine controller.
package shop_pkg;

  localparam int W         = 4;
  localparam int NUM_ITEMS = 4;

  localparam logic [W-1:0] ITEM_A = W'(1);
  localparam logic [W-1:0] ITEM_B = W'(2);
  localparam logic [W-1:0] ITEM_C = W'(3);
  localparam logic [W-1:0] ITEM_D = W'(4);
  localparam logic [W-1:0] UNIT   = W'(1);

  typedef enum logic [1:0] {
    IDLE,
    CREDIT,
    CHANGE
  } state_t;

  // True for the codes that name a real item (1..4).
  function automatic logic is_item(input logic [W-1:0] code);
    return (code >= ITEM_A) && (code <= ITEM_D);
  endfunction

  // Item codes 1..4 map onto table slots 0..3 through their low two bits.
  function automatic logic [1:0] item_idx(input logic [W-1:0] code);
    return code[1:0] - 2'd1;
  endfunction

endpackage

// File: rtl/shop_item_table.sv
// Price/stock table: operator config writes, single-item decrement on sale,
// a lookup port for the purchase logic and the front-panel display mux.
module shop_item_table
  import shop_pkg::*;
(
  input  logic         clk,
  input  logic         reset,
  input  logic [W-1:0] set,
  input  logic [W-1:0] set_quantity,
  input  logic [W-1:0] set_price,
  input  logic         dec_en,
  input  logic [W-1:0] dec_item,
  input  logic [W-1:0] lookup_item,
  output logic [W-1:0] lookup_price,
  output logic [W-1:0] lookup_qty,
  input  logic [W-1:0] display,
  output logic [W-1:0] disp_price [NUM_ITEMS],
  output logic [W-1:0] disp_qty   [NUM_ITEMS]
);

  logic [W-1:0] price_q [NUM_ITEMS];
  logic [W-1:0] price_d [NUM_ITEMS];
  logic [W-1:0] qty_q   [NUM_ITEMS];
  logic [W-1:0] qty_d   [NUM_ITEMS];

  logic [1:0] set_idx;
  logic [1:0] dec_idx;
  logic [1:0] lookup_idx;
  logic [1:0] disp_idx;

  assign set_idx    = item_idx(set);
  assign dec_idx    = item_idx(dec_item);
  assign lookup_idx = item_idx(lookup_item);
  assign disp_idx   = item_idx(display);

  // A config write wins over a sale decrement landing in the same cycle.
  always_comb begin
    price_d = price_q;
    qty_d   = qty_q;
    if (is_item(set)) begin
      price_d[set_idx] = set_price;
      qty_d[set_idx]   = set_quantity;
    end else if (dec_en && (qty_q[dec_idx] != '0)) begin
      qty_d[dec_idx] = qty_q[dec_idx] - UNIT;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      price_q <= '{default: '0};
      qty_q   <= '{default: '0};
    end else begin
      price_q <= price_d;
      qty_q   <= qty_d;
    end
  end

  assign lookup_price = price_q[lookup_idx];
  assign lookup_qty   = qty_q[lookup_idx];

  always_comb begin
    disp_price = '{default: '0};
    disp_qty   = '{default: '0};
    if (display == '0) begin
      disp_price = price_q;
      disp_qty   = qty_q;
    end else if (is_item(display)) begin
      disp_price[disp_idx] = price_q[disp_idx];
      disp_qty[disp_idx]   = qty_q[disp_idx];
    end
  end

endmodule

// File: rtl/shop.sv
// Vending machine top: session FSM (IDLE/CREDIT/CHANGE), credit tracking and
// buy edge detection around the shared price/stock table.
module shop
  import shop_pkg::*;
(
  input  logic         clk,
  input  logic         reset,
  input  logic [W-1:0] set,
  input  logic [W-1:0] display,
  input  logic [W-1:0] set_quantity,
  input  logic [W-1:0] set_price,
  input  logic [W-1:0] money,
  input  logic [W-1:0] buy,
  input  logic         close,
  output logic [W-1:0] goods,
  output logic [W-1:0] balance,
  output logic [W-1:0] priceA,
  output logic [W-1:0] priceB,
  output logic [W-1:0] priceC,
  output logic [W-1:0] priceD,
  output logic [W-1:0] quantityA,
  output logic [W-1:0] quantityB,
  output logic [W-1:0] quantityC,
  output logic [W-1:0] quantityD
);

  state_t       state_q, state_d;
  logic [W-1:0] credit_q, credit_d;
  logic [W-1:0] goods_q, goods_d;
  logic [W-1:0] balance_q, balance_d;
  logic [W-1:0] buy_prev_q, buy_prev_d;

  logic         dec_en;
  logic [W-1:0] lookup_price;
  logic [W-1:0] lookup_qty;
  logic [W-1:0] disp_price [NUM_ITEMS];
  logic [W-1:0] disp_qty   [NUM_ITEMS];

  logic buy_fire;
  logic can_afford;

  shop_item_table u_table (
    .clk          (clk),
    .reset        (reset),
    .set          (set),
    .set_quantity (set_quantity),
    .set_price    (set_price),
    .dec_en       (dec_en),
    .dec_item     (buy),
    .lookup_item  (buy),
    .lookup_price (lookup_price),
    .lookup_qty   (lookup_qty),
    .display      (display),
    .disp_price   (disp_price),
    .disp_qty     (disp_qty)
  );

  // A held buy code fires only once; configuration blocks purchases entirely.
  assign buy_fire   = is_item(buy) && (buy != buy_prev_q) && (set == '0);
  assign can_afford = (lookup_qty != '0) && (credit_q >= lookup_price);

  always_comb begin
    state_d    = state_q;
    credit_d   = credit_q;
    goods_d    = goods_q;
    balance_d  = balance_q;
    buy_prev_d = buy;
    dec_en     = 1'b0;
    case (state_q)
      IDLE: begin
        goods_d   = '0;
        balance_d = '0;
        if ((money != '0) && (set == '0)) begin
          credit_d  = money;
          balance_d = money;
          state_d   = CREDIT;
        end
      end
      CREDIT: begin
        if (close) begin
          goods_d = '0;
          state_d = CHANGE;
        end else if (buy_fire) begin
          if (can_afford) begin
            credit_d  = credit_q - lookup_price;
            balance_d = credit_q - lookup_price;
            goods_d   = buy;
            dec_en    = 1'b1;
          end else begin
            goods_d = '0;
          end
        end
      end
      CHANGE: begin
        balance_d = credit_q;
        goods_d   = '0;
        credit_d  = '0;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      credit_q   <= '0;
      goods_q    <= '0;
      balance_q  <= '0;
      buy_prev_q <= '0;
    end else begin
      state_q    <= state_d;
      credit_q   <= credit_d;
      goods_q    <= goods_d;
      balance_q  <= balance_d;
      buy_prev_q <= buy_prev_d;
    end
  end

  assign goods     = goods_q;
  assign balance   = balance_q;
  assign priceA    = disp_price[0];
  assign priceB    = disp_price[1];
  assign priceC    = disp_price[2];
  assign priceD    = disp_price[3];
  assign quantityA = disp_qty[0];
  assign quantityB = disp_qty[1];
  assign quantityC = disp_qty[2];
  assign quantityD = disp_qty[3];

endmodule

// File: tb/tb_shop.sv
// Directed table-driven bench for the vending machine controller, followed by
// hand-written sequences for sold-out, priority, mid-session config and reset.
module tb_shop;

  typedef struct {
    logic        rst;
    logic [3:0]  set;
    logic [3:0]  disp;
    logic [3:0]  sq;
    logic [3:0]  sp;
    logic [3:0]  money;
    logic [3:0]  buy;
    logic        cls;
    logic [3:0]  eg;
    logic [3:0]  eb;
    logic [15:0] ep;
    logic [15:0] eq;
  } vec_t;

  logic       clk;
  logic       reset;
  logic [3:0] set;
  logic [3:0] display;
  logic [3:0] set_quantity;
  logic [3:0] set_price;
  logic [3:0] money;
  logic [3:0] buy;
  logic       close;
  logic [3:0] goods;
  logic [3:0] balance;
  logic [3:0] priceA, priceB, priceC, priceD;
  logic [3:0] quantityA, quantityB, quantityC, quantityD;

  int total = 0;
  int bad   = 0;

  vec_t vecs [22];

  shop dut (
    .clk          (clk),
    .reset        (reset),
    .set          (set),
    .display      (display),
    .set_quantity (set_quantity),
    .set_price    (set_price),
    .money        (money),
    .buy          (buy),
    .close        (close),
    .goods        (goods),
    .balance      (balance),
    .priceA       (priceA),
    .priceB       (priceB),
    .priceC       (priceC),
    .priceD       (priceD),
    .quantityA    (quantityA),
    .quantityB    (quantityB),
    .quantityC    (quantityC),
    .quantityD    (quantityD)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive one cycle of inputs, then let the edge land and settle.
  task automatic applyStimulus(input vec_t v);
    reset        = v.rst;
    set          = v.set;
    display      = v.disp;
    set_quantity = v.sq;
    set_price    = v.sp;
    money        = v.money;
    buy          = v.buy;
    close        = v.cls;
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input vec_t v, input string tag);
    logic [15:0] got_p;
    logic [15:0] got_q;
    got_p = {priceD, priceC, priceB, priceA};
    got_q = {quantityD, quantityC, quantityB, quantityA};
    total++;
    if (goods !== v.eg) begin
      bad++;
      $display("[TB] FAIL %s goods got=%0d want=%0d", tag, goods, v.eg);
    end
    total++;
    if (balance !== v.eb) begin
      bad++;
      $display("[TB] FAIL %s balance got=%0d want=%0d", tag, balance, v.eb);
    end
    total++;
    if (got_p !== v.ep) begin
      bad++;
      $display("[TB] FAIL %s prices{D,C,B,A} got=%h want=%h", tag, got_p, v.ep);
    end
    total++;
    if (got_q !== v.eq) begin
      bad++;
      $display("[TB] FAIL %s quantities{D,C,B,A} got=%h want=%h", tag, got_q, v.eq);
    end
  endtask

  task automatic step(input string tag, input logic rst, input logic [3:0] s,
                      input logic [3:0] d, input logic [3:0] sq, input logic [3:0] sp,
                      input logic [3:0] m, input logic [3:0] b, input logic c,
                      input logic [3:0] eg, input logic [3:0] eb,
                      input logic [15:0] ep, input logic [15:0] eq);
    vec_t v;
    v = '{rst, s, d, sq, sp, m, b, c, eg, eb, ep, eq};
    applyStimulus(v);
    checkOutput(v, tag);
  endtask

  initial begin
    reset = 1'b1; set = '0; display = '0; set_quantity = '0; set_price = '0;
    money = '0; buy = '0; close = 1'b0;

    //          rst set dsp sq  sp  mon buy cls  goods bal  prices    quantities
    vecs[0]  = '{1, 0,  0,  0,  0,  0,  0,  0,   0,    0,   16'h0000, 16'h0000};
    vecs[1]  = '{0, 1,  0,  10, 5,  0,  0,  0,   0,    0,   16'h0005, 16'h000A};
    vecs[2]  = '{0, 2,  0,  10, 4,  0,  0,  0,   0,    0,   16'h0045, 16'h00AA};
    vecs[3]  = '{0, 3,  0,  10, 3,  0,  0,  0,   0,    0,   16'h0345, 16'h0AAA};
    vecs[4]  = '{0, 4,  0,  10, 10, 0,  0,  0,   0,    0,   16'hA345, 16'hAAAA};
    vecs[5]  = '{0, 0,  1,  0,  0,  10, 0,  0,   0,    10,  16'h0005, 16'h000A};
    vecs[6]  = '{0, 0,  0,  0,  0,  10, 2,  0,   2,    6,   16'hA345, 16'hAA9A};
    vecs[7]  = '{0, 0,  2,  0,  0,  0,  0,  1,   0,    6,   16'h0040, 16'h0090};
    vecs[8]  = '{0, 0,  0,  0,  0,  0,  0,  0,   0,    6,   16'hA345, 16'hAA9A};
    vecs[9]  = '{0, 0,  0,  0,  0,  0,  0,  0,   0,    0,   16'hA345, 16'hAA9A};
    vecs[10] = '{0, 0,  0,  0,  0,  8,  0,  0,   0,    8,   16'hA345, 16'hAA9A};
    vecs[11] = '{0, 0,  0,  0,  0,  0,  4,  0,   0,    8,   16'hA345, 16'hAA9A};
    vecs[12] = '{0, 0,  0,  0,  0,  0,  1,  0,   1,    3,   16'hA345, 16'hAA99};
    vecs[13] = '{0, 0,  0,  0,  0,  0,  0,  1,   0,    3,   16'hA345, 16'hAA99};
    vecs[14] = '{0, 0,  0,  0,  0,  0,  0,  0,   0,    3,   16'hA345, 16'hAA99};
    vecs[15] = '{0, 0,  0,  0,  0,  0,  0,  0,   0,    0,   16'hA345, 16'hAA99};
    vecs[16] = '{0, 0,  0,  0,  0,  15, 0,  0,   0,    15,  16'hA345, 16'hAA99};
    vecs[17] = '{0, 0,  0,  0,  0,  0,  1,  0,   1,    10,  16'hA345, 16'hAA98};
    vecs[18] = '{0, 0,  7,  0,  0,  0,  1,  0,   1,    10,  16'h0000, 16'h0000};
    vecs[19] = '{0, 0,  0,  0,  0,  0,  1,  0,   1,    10,  16'hA345, 16'hAA98};
    vecs[20] = '{0, 0,  0,  0,  0,  0,  0,  0,   1,    10,  16'hA345, 16'hAA98};
    vecs[21] = '{0, 0,  0,  0,  0,  0,  1,  0,   1,    5,   16'hA345, 16'hAA97};

    for (int i = 0; i < 22; i++) begin
      applyStimulus(vecs[i]);
      checkOutput(vecs[i], $sformatf("vec%0d", i));
    end

    // Sold out, then restock C at price 0 mid-session: free while stock lasts.
    step("cfgC_empty",   0, 3, 0, 0, 0, 0, 0, 0, 1, 5, 16'hA045, 16'hA097);
    step("soldout",      0, 0, 0, 0, 0, 0, 3, 0, 0, 5, 16'hA045, 16'hA097);
    step("cfgC_one",     0, 3, 0, 1, 0, 0, 3, 0, 0, 5, 16'hA045, 16'hA197);
    step("idle_buy",     0, 0, 0, 0, 0, 0, 0, 0, 0, 5, 16'hA045, 16'hA197);
    step("free_item",    0, 0, 0, 0, 0, 0, 3, 0, 3, 5, 16'hA045, 16'hA097);
    step("release",      0, 0, 0, 0, 0, 0, 0, 0, 3, 5, 16'hA045, 16'hA097);
    step("qty0_nodec",   0, 0, 0, 0, 0, 0, 3, 0, 0, 5, 16'hA045, 16'hA097);
    step("release2",     0, 0, 0, 0, 0, 0, 0, 0, 0, 5, 16'hA045, 16'hA097);

    // Config together with buy: table updated, purchase suppressed.
    step("set_with_buy", 0, 3, 0, 5, 2, 0, 2, 0, 0, 5, 16'hA245, 16'hA597);
    step("held_buy",     0, 0, 0, 0, 0, 0, 2, 0, 0, 5, 16'hA245, 16'hA597);
    step("release3",     0, 0, 0, 0, 0, 0, 0, 0, 0, 5, 16'hA245, 16'hA597);
    step("new_price",    0, 0, 0, 0, 0, 0, 3, 0, 3, 3, 16'hA245, 16'hA497);

    // close and buy together: refund path, no dispense.
    step("close_buy",    0, 0, 0, 0, 0, 0, 1, 1, 0, 3, 16'hA245, 16'hA497);
    step("change",       0, 0, 0, 0, 0, 0, 0, 0, 0, 3, 16'hA245, 16'hA497);
    step("back_idle",    0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 16'hA245, 16'hA497);

    // Reset mid-session discards credit and the whole table.
    step("load9",        0, 0, 0, 0, 0, 9, 0, 0, 0, 9, 16'hA245, 16'hA497);
    step("reset_mid",    1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 16'h0000, 16'h0000);
    step("post_reset",   0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 16'h0000, 16'h0000);

    // After CHANGE, IDLE reloads credit from a still-nonzero money level.
    step("load4",        0, 0, 0, 0, 0, 4, 0, 0, 0, 4, 16'h0000, 16'h0000);
    step("close4",       0, 0, 0, 0, 0, 4, 0, 1, 0, 4, 16'h0000, 16'h0000);
    step("refund4",      0, 0, 0, 0, 0, 7, 0, 0, 0, 4, 16'h0000, 16'h0000);
    step("reload7",      0, 0, 0, 0, 0, 7, 0, 0, 0, 7, 16'h0000, 16'h0000);
    step("empty_table",  0, 0, 0, 0, 0, 0, 1, 0, 0, 7, 16'h0000, 16'h0000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
